pipe_trace_buffer: RTL and testbench
====================================

// Module: pipe_trace_buffer
// PURPOSE
// - Synthesizable trace capture for the pipelined CPU: samples NUM_CH per-stage words (IF/ID/EX/M/WB) every clk into a circular buffer.
// - Software arms it; a programmable match on one channel triggers capture; POST more cycles are recorded, then the buffer freezes.
// - Frozen entries are read out oldest-first over a valid/ready port.
// - Generalises the per-stage display monitor: parametrised channel count/width/depth, pre/post-trigger window, timestamps.
// PARAMETERS
// - DATA_W  16  width of each channel word
// - NUM_CH  5   number of pipeline channels sampled
// - DEPTH   32  trace entries (power of 2, >=4)
// - TS_W    16  free-running timestamp width
// - AW      $clog2(DEPTH)  derived pointer width; not overridden
// PORTS
// - clk          in   1                 system clock, all logic on posedge
// - reset_n      in   1                 asynchronous active-low reset
// - ch_data      in   NUM_CH*DATA_W     channel c at [c*DATA_W +: DATA_W]
// - ch_valid     in   NUM_CH            per-channel valid (0 = bubble/flush)
// - arm          in   1                 1-cycle pulse: clear buffer, enter ARMED
// - force_trig   in   1                 trigger unconditionally when ARMED
// - trig_ch      in   $clog2(NUM_CH)    channel compared for trigger
// - trig_value   in   DATA_W            match value
// - trig_mask    in   DATA_W            1 = bit compared; all-0 = any valid word
// - post_count   in   AW                entries captured after trigger entry
// - state_o      out  2                 IDLE=0 ARMED=1 POST=2 DONE=3
// - entries      out  AW+1              entries held (0..DEPTH)
// - rd_valid     out  1                 rd_data holds an unread entry
// - rd_ready     in   1                 consumer accepts rd_data
// - rd_data      out  TS_W+NUM_CH+NUM_CH*DATA_W  {timestamp, ch_valid, ch_data}
// - rd_trig      out  1                 rd_data is the trigger entry
// BEHAVIOUR
// - Reset: state IDLE, wr_ptr=0, rd_ptr=0, entries=0, ts=0, rd_valid=0, rd_trig=0, rd_data=0.
// - ts increments every cycle from reset, wraps at 2^TS_W; each stored entry carries ts at sample time.
// - IDLE: nothing written. arm -> ARMED next cycle; buffer cleared (entries=0, wr_ptr=0).
// - ARMED: write one entry per cycle at wr_ptr, wr_ptr wraps mod DEPTH, entries saturates at DEPTH (oldest overwritten).
// - Trigger hit = ARMED && (force_trig || (ch_valid[trig_ch] && ((ch_slice ^ trig_value) & trig_mask)==0)).
// - Hit cycle: entry still written, its index latched as trig_idx; -> POST with post_left=post_count; if post_count==0 -> DONE directly.
// - POST: write each cycle, decrement post_left; entry written with post_left==1 is the last -> DONE.
// - trig_ch >= NUM_CH: match never hits (force_trig still works).
// - post_count >= DEPTH-1 clamps to DEPTH-1 so the trigger entry is never overwritten.
// - DONE: writes stop; rd_ptr = (entries<DEPTH) ? 0 : wr_ptr (oldest). rd_valid=1 one cycle after entering DONE when entries>0.
// - Readout: registered; rd_valid&&rd_ready pops, rd_ptr+1 mod DEPTH, entries-1; next entry presented on next cycle (full throughput); rd_valid falls after last pop.
// - rd_data/rd_trig stable while rd_valid&&!rd_ready. rd_trig=1 iff presented index == trig_idx.
// - DONE && entries==0 -> IDLE. arm in any state restarts (abandons readout, clears); arm wins over same-cycle trigger/pop.
// - Hit and arm same cycle: arm wins, hit ignored. Trigger in cycle 1 of ARMED is legal (pre-trigger history = 1 entry).
// - reset_n low mid-capture or mid-readout: immediate return to reset values; storage contents need not be cleared.
// STRUCTURE
// - Shared cpu package: state enum (TRC_IDLE..TRC_DONE), entry-width function, channel index constants CH_IF..CH_WB.
// - One sub-module: trace_ram (DEPTH x entry width, 1 write port, 1 registered read port, no reset on array).
// - Top holds FSM, pointers, counters, trigger comparator, timestamp.
// TESTING
// - Reset: after reset_n 0->1, state_o=0, entries=0, rd_valid=0; ch_data toggling writes nothing.
// - Pre-trigger wrap: arm, 40 cycles, ch0 (IF) data=cycle#, trig_value=0x0027 mask=0xFFFF, post_count=3 -> 32 entries read, first ch0=0x000B, rd_trig on ch0=0x0027 (entry 29), last ch0=0x002A.
// - Short capture: arm, force_trig 3rd cycle, post_count=0 -> entries=3, rd_trig on 3rd, state IDLE after 3 pops.
// - Mask/valid: trig_mask=0x00F0, trig_value=0x0050, ch_valid[trig_ch]=0 with data 0x1257 -> no hit; valid=1 data 0xAB5C -> hit.
// - Backpressure: rd_ready random 50%; every entry seen once in order, ts strictly +1 between consecutive entries.
// - Restart: arm during readout after 5 pops -> entries=0, ARMED; reset_n low in POST -> all outputs reset values.

Source files
------------

// File: rtl/pipe_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_trace_buffer_pkg
// Description : Shared definitions for the pipeline trace buffer: capture
//               state encoding, pipeline channel indices and the helper that
//               sizes one stored trace entry.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_trace_buffer_pkg;

    // Capture state machine; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        TRC_IDLE  = 2'd0,
        TRC_ARMED = 2'd1,
        TRC_POST  = 2'd2,
        TRC_DONE  = 2'd3
    } trc_state_t;

    // Channel slots of the five-stage CPU pipeline.
    localparam int CH_IF  = 0;
    localparam int CH_ID  = 1;
    localparam int CH_EX  = 2;
    localparam int CH_MEM = 3;
    localparam int CH_WB  = 4;
    localparam int CH_NUM = CH_WB + 1;

    // Width of one trace entry: {timestamp, per-channel valid, channel words}.
    function automatic int trc_entry_w(input int ts_w, input int num_ch, input int data_w);
        return ts_w + num_ch + num_ch * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_trace_buffer_trace_ram.sv
`default_nettype none
// ============================================================================
// Module      : pipe_trace_buffer_trace_ram
// Description : Trace storage. DEPTH x WIDTH array with one write port and
//               one registered read port. The array itself is not reset; the
//               read register is, so the consumer sees zero after reset.
// Ports       : clk, reset_n          clock / async active-low reset
//               we, waddr, wdata      write port
//               re, raddr, rdata      registered read port (rdata holds when !re)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_buffer_trace_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 101,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_trace_buffer
// Description : Pipeline trace capture. While armed, every cycle samples the
//               NUM_CH stage words into a circular buffer; a programmable
//               match (or force_trig) on one channel triggers, post_count more
//               entries are taken, then the buffer freezes and is read out
//               oldest-first over a valid/ready port.
// Ports       : clk, reset_n                    clock / async active-low reset
//               ch_data, ch_valid               sampled pipeline channels
//               arm, force_trig                 control pulses
//               trig_ch, trig_value, trig_mask  trigger comparator setup
//               post_count                      entries after the trigger entry
//               state_o, entries                status
//               rd_valid, rd_ready, rd_data,
//               rd_trig                         readout port
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_buffer
    import pipe_trace_buffer_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  NUM_CH = CH_NUM,
    parameter int  DEPTH  = 32,
    parameter int  TS_W   = 16,
    parameter int  AW     = $clog2(DEPTH),
    localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int EW     = trc_entry_w(TS_W, NUM_CH, DATA_W)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic                     arm,
    input  logic                     force_trig,
    input  logic [CW-1:0]            trig_ch,
    input  logic [DATA_W-1:0]        trig_value,
    input  logic [DATA_W-1:0]        trig_mask,
    input  logic [AW-1:0]            post_count,
    output logic [1:0]               state_o,
    output logic [AW:0]              entries,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [EW-1:0]            rd_data,
    output logic                     rd_trig
);

    trc_state_t      state, state_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr, trig_idx, post_left;
    logic [TS_W-1:0] ts;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              match, hit;
    logic [AW-1:0]     post_clamped;
    logic              we;
    logic [AW-1:0]     wr_ptr_inc;
    logic [AW:0]       entries_inc;
    logic              pop, re;
    logic [AW-1:0]     fetch_idx;
    logic [AW:0]       remain;

    // Trigger channel select; an out-of-range trig_ch leaves sel_valid low,
    // so only force_trig can fire in that case.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (trig_ch == CW'(c)) begin
                sel_data  = ch_data[c*DATA_W +: DATA_W];
                sel_valid = ch_valid[c];
            end
        end
    end

    assign match = sel_valid && (((sel_data ^ trig_value) & trig_mask) == '0);
    assign hit   = (state == TRC_ARMED) && (force_trig || match);

    // Longest post window keeps the trigger entry as the oldest survivor.
    assign post_clamped = (post_count >= AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : post_count;

    assign we          = ((state == TRC_ARMED) || (state == TRC_POST)) && !arm;
    assign wr_ptr_inc  = wr_ptr + 1'b1;
    assign entries_inc = (entries == (AW+1)'(DEPTH)) ? entries : entries + 1'b1;

    // rd_ptr always names the entry currently presented (or about to be).
    // On a pop the following entry is fetched in the same cycle so the port
    // sustains one entry per cycle.
    assign pop       = (state == TRC_DONE) && rd_valid && rd_ready && !arm;
    assign fetch_idx = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign remain    = pop ? entries - 1'b1 : entries;
    assign re        = (state == TRC_DONE) && !arm && (!rd_valid || pop) && (remain != '0);

    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = TRC_ARMED;
        end else begin
            case (state)
                TRC_IDLE:  state_nxt = TRC_IDLE;
                TRC_ARMED: if (hit) state_nxt = (post_clamped == '0) ? TRC_DONE : TRC_POST;
                TRC_POST:  if (post_left == AW'(1)) state_nxt = TRC_DONE;
                TRC_DONE:  if (entries == '0) state_nxt = TRC_IDLE;
                default:   state_nxt = TRC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= TRC_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            entries   <= '0;
            ts        <= '0;
            trig_idx  <= '0;
            post_left <= '0;
            rd_valid  <= 1'b0;
            rd_trig   <= 1'b0;
        end else begin
            state <= state_nxt;
            ts    <= ts + 1'b1;
            if (arm) begin
                wr_ptr   <= '0;
                entries  <= '0;
                rd_valid <= 1'b0;
                rd_trig  <= 1'b0;
            end else begin
                if (we) begin
                    wr_ptr  <= wr_ptr_inc;
                    entries <= entries_inc;
                end
                if (hit) begin
                    trig_idx  <= wr_ptr;
                    post_left <= post_clamped;
                end else if (state == TRC_POST) begin
                    post_left <= post_left - 1'b1;
                end
                // Freeze: oldest entry is slot 0 until the buffer has wrapped.
                if ((state_nxt == TRC_DONE) && (state != TRC_DONE)) begin
                    rd_ptr <= (entries_inc < (AW+1)'(DEPTH)) ? '0 : wr_ptr_inc;
                end
                if (state == TRC_DONE) begin
                    if (pop) begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        entries <= entries - 1'b1;
                    end
                    if (re) begin
                        rd_valid <= 1'b1;
                        rd_trig  <= (fetch_idx == trig_idx);
                    end else if (pop) begin
                        rd_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign state_o = state;

    pipe_trace_buffer_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (wr_ptr),
        .wdata   ({ts, ch_valid, ch_data}),
        .re      (re),
        .raddr   (fetch_idx),
        .rdata   (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_trace_buffer
// Description : Self-checking bench for pipe_trace_buffer. Trigger comparator
//               vectors come from a table; capture runs push expected entries
//               into a scoreboard queue that is popped as the readout port
//               delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_trace_buffer;

    localparam int EW = 16 + 5 + 80;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [79:0]   ch_data;
    logic [4:0]    ch_valid;
    logic          arm, force_trig;
    logic [2:0]    trig_ch;
    logic [15:0]   trig_value, trig_mask;
    logic [4:0]    post_count;
    logic [1:0]    state_o;
    logic [5:0]    entries;
    logic          rd_valid, rd_ready, rd_trig;
    logic [EW-1:0] rd_data;

    always #5 clk = ~clk;

    pipe_trace_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_ch    (trig_ch),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .post_count (post_count),
        .state_o    (state_o),
        .entries    (entries),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_trig    (rd_trig)
    );

    // Reference timestamp: counts every cycle out of reset.
    logic [15:0] m_ts;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_ts <= '0;
        else          m_ts <= m_ts + 16'd1;
    end

    typedef struct {
        logic [EW-1:0] d;
        logic          t;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic [2:0]  tch;
        logic [15:0] val;
        logic [15:0] mask;
        logic        frc;
        logic [4:0]  vld;
        logic [79:0] data;
        logic        hit;
    } vec_t;
    vec_t vt[10];

    int checks = 0;
    int errors = 0;
    int popped, first_ch0, last_ch0, trig_ch0, trig_pos;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        ch_valid = '0;
        arm      = 1'b1;
        step();
        arm      = 1'b0;
        q.delete();
    endtask

    function automatic logic model_hit(input logic frc, input logic [4:0] vld, input logic [79:0] dat);
        logic [15:0] w;
        if (frc) return 1'b1;
        if (trig_ch > 3'd4) return 1'b0;
        w = dat[trig_ch*16 +: 16];
        return vld[trig_ch] && (((w ^ trig_value) & trig_mask) == 16'h0);
    endfunction

    // Drives capture cycles starting in ARMED; stops when the model reaches
    // DONE or after max_cyc cycles. ch0 carries the cycle index.
    task automatic capture(input int force_at, input int pc, input int max_cyc);
        int   st, left, pcc;
        logic h;
        ent_t e;
        logic [79:0] dat;
        logic [4:0]  vld;
        st = 1;
        left = 0;
        pcc = (pc >= 31) ? 31 : pc;
        post_count = 5'(pc);
        for (int i = 0; i < max_cyc; i++) begin
            dat = {16'($urandom), 16'($urandom), 16'($urandom), 16'(i ^ 'h5555), 16'(i)};
            vld = {2'($urandom), 3'b111};
            h = (st == 1) && model_hit(i == force_at, vld, dat);
            e.d = {m_ts, vld, dat};
            e.t = h;
            q.push_back(e);
            if (q.size() > 32) void'(q.pop_front());
            ch_data    = dat;
            ch_valid   = vld;
            force_trig = (i == force_at);
            if (st == 1 && h) begin
                left = pcc;
                st = (pcc == 0) ? 3 : 2;
            end else if (st == 2) begin
                if (left == 1) st = 3;
                left--;
            end
            step();
            force_trig = 1'b0;
            if (st == 3) break;
        end
        ch_valid = '0;
    endtask

    task automatic drain(input int prob, input int max_pops, input int budget);
        ent_t        e;
        logic [15:0] ts_prev;
        int          cyc;
        popped = 0;
        ts_prev = '0;
        for (cyc = 0; cyc < budget; cyc++) begin
            if (max_pops > 0 && popped == max_pops) break;
            if (!rd_valid && q.size() == 0) break;
            rd_ready = ($urandom_range(99) < prob);
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) begin
                    chk("rd_extra_entry", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_trig", rd_trig, e.t);
                    if (popped == 0) first_ch0 = int'(rd_data[15:0]);
                    else chk("ts_step", rd_data[100:85], ts_prev + 16'd1);
                    last_ch0 = int'(rd_data[15:0]);
                    if (rd_trig) begin
                        trig_ch0 = int'(rd_data[15:0]);
                        trig_pos = popped;
                    end
                    ts_prev = rd_data[100:85];
                    popped++;
                end
            end
            step();
        end
        rd_ready = 1'b0;
        if (cyc == budget) chk("drain_budget", 1, 0);
    endtask

    initial begin
        vt[0] = '{3'd0, 16'h0050, 16'h00F0, 1'b0, 5'h1E, {64'h0, 16'h1257}, 1'b0};
        vt[1] = '{3'd0, 16'h0050, 16'h00F0, 1'b0, 5'h1F, {64'h0, 16'hAB5C}, 1'b1};
        vt[2] = '{3'd0, 16'h0050, 16'h00F0, 1'b0, 5'h1F, {64'h0, 16'h1267}, 1'b0};
        vt[3] = '{3'd0, 16'h1234, 16'h0000, 1'b0, 5'h01, {64'h0, 16'h9999}, 1'b1};
        vt[4] = '{3'd0, 16'h1234, 16'h0000, 1'b0, 5'h1E, {64'h0, 16'h9999}, 1'b0};
        vt[5] = '{3'd2, 16'hBEEF, 16'hFFFF, 1'b0, 5'h1F, {32'h0, 16'hBEEF, 32'h0}, 1'b1};
        vt[6] = '{3'd2, 16'hBEEF, 16'hFFFF, 1'b0, 5'h1F, {32'h0, 16'h1111, 16'h0, 16'hBEEF}, 1'b0};
        vt[7] = '{3'd5, 16'h0000, 16'h0000, 1'b0, 5'h1F, 80'h0, 1'b0};
        vt[8] = '{3'd7, 16'h0000, 16'hFFFF, 1'b1, 5'h00, 80'h0, 1'b1};
        vt[9] = '{3'd4, 16'h1234, 16'hFFFF, 1'b0, 5'h10, {16'h1234, 64'h0}, 1'b1};

        reset_n = 1'b0; ch_data = '0; ch_valid = '0; arm = 1'b0; force_trig = 1'b0;
        trig_ch = '0; trig_value = '0; trig_mask = '0; post_count = '0; rd_ready = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("reset_state", state_o, 0);
        chk("reset_entries", entries, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_rd_trig", rd_trig, 0);
        for (int i = 0; i < 5; i++) begin
            ch_data = {5{16'(i * 'h1111)}};
            ch_valid = 5'h1F;
            force_trig = 1'b1;
            step();
            chk("idle_entries", entries, 0);
            chk("idle_state", state_o, 0);
        end
        force_trig = 1'b0;

        // Trigger comparator vectors: one armed cycle each, post_count 0.
        post_count = '0;
        for (int v = 0; v < 10; v++) begin
            trig_ch = vt[v].tch; trig_value = vt[v].val; trig_mask = vt[v].mask;
            do_arm();
            ch_data = vt[v].data; ch_valid = vt[v].vld; force_trig = vt[v].frc;
            step();
            force_trig = 1'b0; ch_valid = '0;
            chk($sformatf("vec%0d_state", v), state_o, vt[v].hit ? 3 : 1);
            chk($sformatf("vec%0d_entries", v), entries, 1);
        end

        // Pre-trigger wrap.
        trig_ch = 3'd0; trig_value = 16'h0027; trig_mask = 16'hFFFF;
        do_arm();
        capture(-1, 3, 60);
        chk("wrap_state", state_o, 3);
        chk("wrap_entries", entries, 32);
        drain(100, 0, 200);
        chk("wrap_count", popped, 32);
        chk("wrap_first", first_ch0, 'h0B);
        chk("wrap_trig", trig_ch0, 'h27);
        chk("wrap_trig_pos", trig_pos, 28);
        chk("wrap_last", last_ch0, 'h2A);
        step();
        chk("wrap_idle", state_o, 0);

        // Short capture: force on the third armed cycle, no post window.
        trig_value = 16'hFFFF;
        do_arm();
        capture(2, 0, 10);
        chk("short_entries", entries, 3);
        drain(100, 0, 50);
        chk("short_count", popped, 3);
        chk("short_trig_pos", trig_pos, 2);
        step();
        chk("short_idle", state_o, 0);

        // Backpressure readout.
        do_arm();
        capture(10, 8, 40);
        chk("bp_entries", entries, 19);
        drain(50, 0, 400);
        chk("bp_count", popped, 19);
        chk("bp_queue_empty", q.size(), 0);

        // Restart during readout, then reset during POST.
        do_arm();
        capture(3, 20, 40);
        chk("rs_entries", entries, 24);
        drain(100, 5, 50);
        chk("rs_popped", popped, 5);
        do_arm();
        chk("rearm_state", state_o, 1);
        chk("rearm_entries", entries, 0);
        chk("rearm_rd_valid", rd_valid, 0);
        capture(0, 10, 4);
        chk("post_state", state_o, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_entries", entries, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_trig", rd_trig, 0);
        step();
        reset_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
